// File: rtl/sram_arbiter_pkg.sv
// Shared types for the two-port SRAM arbiter: FSM state encoding and port identifiers.
package sram_arb_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        RESP   = 2'd2
    } state_t;

    typedef enum logic {
        PORT_A = 1'b0,
        PORT_B = 1'b1
    } port_t;

    function automatic logic [1:0] port_onehot(input port_t p);
        return (p == PORT_B) ? 2'b10 : 2'b01;
    endfunction

endpackage

// File: rtl/sram_arbiter_pick.sv
// Combinational 2-way picker: round-robin on ties by default,
// fixed priority to port A when SRAM_ARB_FIXED_PRIO_EN is defined.
module sram_arb_pick
    import sram_arb_pkg::*;
(
    input  logic [1:0] req,
    input  port_t      last,
    output port_t      winner,
    output logic       valid
);

    always_comb begin
        valid  = |req;
        winner = PORT_A;
`ifdef SRAM_ARB_FIXED_PRIO_EN
        if (!req[0] && req[1]) begin
            winner = PORT_B;
        end
`else
        case (req)
            2'b10:   winner = PORT_B;
            2'b11:   winner = (last == PORT_A) ? PORT_B : PORT_A;
            default: winner = PORT_A;
        endcase
`endif
    end

endmodule

// File: rtl/sram_arbiter.sv
// Two-requester arbiter in front of a single-port SRAM with registered read data.
// SRAM_ARB_FIXED_PRIO_EN: port A always wins ties and the round-robin pointer is removed.
module sram_arbiter
    import sram_arb_pkg::*;
#(
    parameter int ADR  = 8,
    parameter int DAT  = 8,
    parameter int DPTH = 8
) (
    input  logic             Clk,
    input  logic             Rst_n,
    input  logic [1:0]       req,
    input  logic [1:0]       we,
    input  logic [2*ADR-1:0] addr,
    input  logic [2*DAT-1:0] wdata,
    output logic [1:0]       gnt,
    output logic [1:0]       rvalid,
    output logic [DAT-1:0]   rdata,
    output logic             err,
    output logic [DAT-1:0]   sram_dataIn,
    output logic [ADR-1:0]   sram_Addr,
    output logic             sram_WE,
    output logic             sram_RD,
    input  logic [DAT-1:0]   sram_dataOut
);

    localparam logic [ADR:0] DPTH_W = (ADR+1)'(DPTH);

    state_t         state_q, state_d;
    port_t          win_q, win_d;
    logic           rd_pend_q, rd_pend_d;
    logic [1:0]     gnt_d, rvalid_d;
    logic           err_d, we_d, rd_d;
    logic [ADR-1:0] addr_d;
    logic [DAT-1:0] din_d;
    logic [DAT-1:0] rdata_q, rdata_d;

    port_t          pick;
    logic           pick_valid;
    port_t          last_w;

    logic [ADR-1:0] sel_addr;
    logic [DAT-1:0] sel_wdata;
    logic           sel_we;
    logic           sel_in_range;

`ifdef SRAM_ARB_FIXED_PRIO_EN
    assign last_w = PORT_A;
`else
    port_t last_q, last_d;
    assign last_w = last_q;
`endif

    sram_arb_pick u_pick (
        .req    (req),
        .last   (last_w),
        .winner (pick),
        .valid  (pick_valid)
    );

    assign sel_addr     = (pick == PORT_B) ? addr[2*ADR-1:ADR]  : addr[ADR-1:0];
    assign sel_wdata    = (pick == PORT_B) ? wdata[2*DAT-1:DAT] : wdata[DAT-1:0];
    assign sel_we       = (pick == PORT_B) ? we[1] : we[0];
    assign sel_in_range = ({1'b0, sel_addr} < DPTH_W);

    // The SRAM's read data is already registered, so during RESP it is forwarded
    // straight through; the holding register keeps it stable between pulses.
    assign rdata = (state_q == RESP) ? sram_dataOut : rdata_q;

    always_comb begin
        state_d   = state_q;
        win_d     = win_q;
        rd_pend_d = rd_pend_q;
        gnt_d     = '0;
        rvalid_d  = '0;
        err_d     = 1'b0;
        we_d      = 1'b0;
        rd_d      = 1'b0;
        addr_d    = sram_Addr;
        din_d     = sram_dataIn;
        rdata_d   = rdata_q;
`ifndef SRAM_ARB_FIXED_PRIO_EN
        last_d    = last_q;
`endif
        case (state_q)
            IDLE: begin
                if (pick_valid) begin
                    state_d   = ACCESS;
                    win_d     = pick;
                    gnt_d     = port_onehot(pick);
                    addr_d    = sel_addr;
                    din_d     = sel_wdata;
                    err_d     = !sel_in_range;
                    we_d      = sel_in_range && sel_we;
                    rd_d      = sel_in_range && !sel_we;
                    rd_pend_d = sel_in_range && !sel_we;
`ifndef SRAM_ARB_FIXED_PRIO_EN
                    last_d    = pick;
`endif
                end
            end
            ACCESS: begin
                if (rd_pend_q) begin
                    state_d  = RESP;
                    rvalid_d = port_onehot(win_q);
                end else begin
                    state_d  = IDLE;
                end
            end
            RESP: begin
                rdata_d   = sram_dataOut;
                rd_pend_d = 1'b0;
                state_d   = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            state_q     <= IDLE;
            win_q       <= PORT_A;
            rd_pend_q   <= 1'b0;
            gnt         <= '0;
            rvalid      <= '0;
            err         <= 1'b0;
            sram_WE     <= 1'b0;
            sram_RD     <= 1'b0;
            sram_Addr   <= '0;
            sram_dataIn <= '0;
            rdata_q     <= '0;
        end else begin
            state_q     <= state_d;
            win_q       <= win_d;
            rd_pend_q   <= rd_pend_d;
            gnt         <= gnt_d;
            rvalid      <= rvalid_d;
            err         <= err_d;
            sram_WE     <= we_d;
            sram_RD     <= rd_d;
            sram_Addr   <= addr_d;
            sram_dataIn <= din_d;
            rdata_q     <= rdata_d;
        end
    end

`ifndef SRAM_ARB_FIXED_PRIO_EN
    // Reset to B so that the very first tie goes to port A.
    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            last_q <= PORT_B;
        end else begin
            last_q <= last_d;
        end
    end
`endif

endmodule

// File: tb/tb_sram_arbiter.sv
// Scoreboarded random test of sram_arbiter against a transaction-level model
// (honours SRAM_ARB_FIXED_PRIO_EN for tie prediction).
module tb_sram_arbiter;

    localparam int ADR  = 8;
    localparam int DAT  = 8;
    localparam int DPTH = 8;

    logic             Clk = 1'b0;
    logic             Rst_n = 1'b0;
    logic [1:0]       req = '0;
    logic [1:0]       we = '0;
    logic [2*ADR-1:0] addr = '0;
    logic [2*DAT-1:0] wdata = '0;
    logic [1:0]       gnt, rvalid;
    logic [DAT-1:0]   rdata, sram_dataIn, sram_dataOut;
    logic [ADR-1:0]   sram_Addr;
    logic             err, sram_WE, sram_RD;

    sram_arbiter #(.ADR(ADR), .DAT(DAT), .DPTH(DPTH)) dut (
        .Clk          (Clk),
        .Rst_n        (Rst_n),
        .req          (req),
        .we           (we),
        .addr         (addr),
        .wdata        (wdata),
        .gnt          (gnt),
        .rvalid       (rvalid),
        .rdata        (rdata),
        .err          (err),
        .sram_dataIn  (sram_dataIn),
        .sram_Addr    (sram_Addr),
        .sram_WE      (sram_WE),
        .sram_RD      (sram_RD),
        .sram_dataOut (sram_dataOut)
    );

    always #5 Clk = ~Clk;

    // Behavioural SRAM with registered read port.
    logic [DAT-1:0] sram_mem [DPTH];
    always @(posedge Clk) begin
        if (sram_WE) sram_mem[sram_Addr[2:0]] <= sram_dataIn;
        if (sram_RD) sram_dataOut <= sram_mem[sram_Addr[2:0]];
    end

    typedef struct {
        logic [1:0]     gnt;
        logic           err;
        logic           wr;
        logic           rd;
        logic [ADR-1:0] a;
        logic [DAT-1:0] d;
    } gexp_t;

    typedef struct {
        logic [1:0]     port;
        logic [DAT-1:0] d;
    } rexp_t;

    gexp_t gq[$];
    rexp_t rq[$];
    int n_chk  = 0;
    int n_fail = 0;

    logic [DAT-1:0] model_mem [DPTH];
    int last_served = 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic int tie_winner();
`ifdef SRAM_ARB_FIXED_PRIO_EN
        return 0;
`else
        return (last_served == 0) ? 1 : 0;
`endif
    endfunction

    // Model one served access: memory effect, expected grant and read response.
    task automatic predict(input int p, input logic w, input logic [ADR-1:0] a, input logic [DAT-1:0] d);
        gexp_t g;
        rexp_t r;
        logic  in_range;
        in_range = (int'(a) < DPTH);
        g.gnt = (p == 0) ? 2'b01 : 2'b10;
        g.err = !in_range;
        g.wr  = in_range && w;
        g.rd  = in_range && !w;
        g.a   = a;
        g.d   = d;
        gq.push_back(g);
        if (in_range && w) model_mem[a[2:0]] = d;
        if (in_range && !w) begin
            r.port = g.gnt;
            r.d    = model_mem[a[2:0]];
            rq.push_back(r);
        end
        last_served = p;
    endtask

    task automatic drive(input int p, input logic w, input logic [ADR-1:0] a, input logic [DAT-1:0] d);
        if (p == 0) begin
            we[0] = w; addr[ADR-1:0] = a; wdata[DAT-1:0] = d;
        end else begin
            we[1] = w; addr[2*ADR-1:ADR] = a; wdata[2*DAT-1:DAT] = d;
        end
    endtask

    task automatic wait_all_gnt(input int budget);
        int k;
        k = 0;
        while (req != 2'b00 && k < budget) begin
            @(posedge Clk); #1;
            req = req & ~gnt;
            k++;
        end
        if (req != 2'b00) begin
            check("gnt_timeout", 32'(req), 32'h0);
            req = 2'b00;
        end
    endtask

    task automatic settle();
        repeat (4) @(posedge Clk);
        #1;
    endtask

    task automatic single(input int p, input logic w, input logic [ADR-1:0] a, input logic [DAT-1:0] d);
        drive(p, w, a, d);
        predict(p, w, a, d);
        req[p] = 1'b1;
        wait_all_gnt(10);
        settle();
    endtask

    task automatic dual(input logic wa, input logic [ADR-1:0] aa, input logic [DAT-1:0] da,
                        input logic wb, input logic [ADR-1:0] ab, input logic [DAT-1:0] db);
        int first;
        drive(0, wa, aa, da);
        drive(1, wb, ab, db);
        first = tie_winner();
        if (first == 0) begin
            predict(0, wa, aa, da); predict(1, wb, ab, db);
        end else begin
            predict(1, wb, ab, db); predict(0, wa, aa, da);
        end
        req = 2'b11;
        wait_all_gnt(20);
        settle();
    endtask

    function automatic logic [ADR-1:0] rand_addr();
        if ($urandom_range(0, 5) == 0) return ADR'($urandom_range(DPTH, 255));
        return ADR'($urandom_range(0, DPTH-1));
    endfunction

    // Monitor: pops expectations whenever the DUT pulses a grant or read-valid.
    logic [DAT-1:0] last_rdata = '0;
    always @(negedge Clk) begin
        gexp_t g;
        rexp_t r;
        if (!Rst_n) begin
            last_rdata = '0;
        end else begin
            check("strobe_excl", 32'(sram_WE & sram_RD), 32'h0);
            if (gnt != 2'b00) begin
                if (gq.size() == 0) begin
                    check("unexpected_gnt", 32'(gnt), 32'h0);
                end else begin
                    g = gq.pop_front();
                    check("gnt", 32'(gnt), 32'(g.gnt));
                    check("err", 32'(err), 32'(g.err));
                    check("sram_WE", 32'(sram_WE), 32'(g.wr));
                    check("sram_RD", 32'(sram_RD), 32'(g.rd));
                    if (g.wr || g.rd) check("sram_Addr", 32'(sram_Addr), 32'(g.a));
                    if (g.wr) check("sram_dataIn", 32'(sram_dataIn), 32'(g.d));
                end
            end else begin
                check("idle_strobes", 32'({err, sram_WE, sram_RD}), 32'h0);
            end
            if (rvalid != 2'b00) begin
                if (rq.size() == 0) begin
                    check("unexpected_rvalid", 32'(rvalid), 32'h0);
                end else begin
                    r = rq.pop_front();
                    check("rvalid", 32'(rvalid), 32'(r.port));
                    check("rdata", 32'(rdata), 32'(r.d));
                    last_rdata = r.d;
                end
            end else begin
                check("rdata_hold", 32'(rdata), 32'(last_rdata));
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        int cnt;
        logic [ADR-1:0] a0, a1;

        for (int i = 0; i < DPTH; i++) model_mem[i] = '0;

        repeat (2) @(posedge Clk);
        #1;
        check("rst_outs", 32'({gnt, rvalid, err, sram_WE, sram_RD}), 32'h0);
        check("rst_data", 32'({rdata, sram_Addr, sram_dataIn}), 32'h0);
        Rst_n = 1'b1;
        @(posedge Clk); #1;
        check("post_rst_outs", 32'({gnt, rvalid, err, sram_WE, sram_RD}), 32'h0);

        for (int i = 0; i < DPTH; i++) single(0, 1'b1, ADR'(i), DAT'($urandom));

        // Directed: write, read-back from the other port, out-of-range read.
        single(0, 1'b1, 8'd3, 8'h5A);
        single(1, 1'b0, 8'd3, 8'h00);
        single(0, 1'b0, 8'd8, 8'h00);

        // Write then immediate read of the same word from the other port.
        drive(0, 1'b1, 8'd5, 8'hC3);
        predict(0, 1'b1, 8'd5, 8'hC3);
        req[0] = 1'b1;
        wait_all_gnt(10);
        drive(1, 1'b0, 8'd5, 8'h00);
        predict(1, 1'b0, 8'd5, 8'h00);
        req[1] = 1'b1;
        wait_all_gnt(10);
        settle();

        // Continuous dual read requests: ties resolved by the model each time.
        a0 = ADR'($urandom_range(0, DPTH-1));
        a1 = ADR'($urandom_range(0, DPTH-1));
        drive(0, 1'b0, a0, 8'h00);
        drive(1, 1'b0, a1, 8'h00);
        for (int k = 0; k < 6; k++) begin
            if (tie_winner() == 0) predict(0, 1'b0, a0, 8'h00);
            else                   predict(1, 1'b0, a1, 8'h00);
        end
        req = 2'b11;
        cnt = 0;
        for (int k = 0; k < 60 && cnt < 6; k++) begin
            @(posedge Clk); #1;
            if (gnt != 2'b00) cnt++;
        end
        req = 2'b00;
        check("cont_grants", 32'(cnt), 32'd6);
        settle();

        // Random traffic.
        for (int it = 0; it < 60; it++) begin
            case ($urandom_range(0, 2))
                0: single(0, 1'($urandom), rand_addr(), DAT'($urandom));
                1: single(1, 1'($urandom), rand_addr(), DAT'($urandom));
                default: dual(1'($urandom), rand_addr(), DAT'($urandom),
                              1'($urandom), rand_addr(), DAT'($urandom));
            endcase
        end

        // Reset during the ACCESS cycle of a read aborts it.
        drive(0, 1'b0, 8'd2, 8'h00);
        req[0] = 1'b1;
        @(posedge Clk); #1;
        check("abort_gnt_seen", 32'(gnt), 32'h1);
        check("abort_rd_seen", 32'(sram_RD), 32'h1);
        #1 Rst_n = 1'b0;
        #1;
        check("abort_rd_drop", 32'(sram_RD), 32'h0);
        check("abort_gnt_drop", 32'(gnt), 32'h0);
        req = 2'b00;
        repeat (2) @(posedge Clk);
        #1 Rst_n = 1'b1;
        last_served = 1;
        repeat (5) @(posedge Clk);
        #1;
        dual(1'b0, 8'd1, 8'h00, 1'b0, 8'd6, 8'h00);

        check("gq_empty", 32'(gq.size()), 32'h0);
        check("rq_empty", 32'(rq.size()), 32'h0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
